// File: rtl/tank_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tank_motion_ctrl
// Brief    : Per-player tank state engine: rate-limited moves/turns checked
//            against the wall map, plus a cooldown-limited fire request.
// Revision : 1.0 - initial release
// ============================================================================
module tank_motion_ctrl #(
    parameter int GAME_W        = 64,
    parameter int GAME_H        = 48,
    parameter int INIT_X        = 10,
    parameter int INIT_Y        = 24,
    parameter int INIT_DIR      = 0,
    parameter int MOVE_PERIOD   = 4,
    parameter int FIRE_COOLDOWN = 30
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic [3:0] i_btn,
    input  logic       i_fire,
    output logic       o_chk_valid,
    output logic [6:0] o_chk_x,
    output logic [6:0] o_chk_y,
    input  logic       i_chk_wall,
    output logic [6:0] o_tank_x,
    output logic [6:0] o_tank_y,
    output logic [1:0] o_tank_dir,
    output logic       o_fire_pulse,
    output logic [6:0] o_fire_x,
    output logic [6:0] o_fire_y,
    output logic [1:0] o_fire_dir,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int MW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam int FW = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN) : 1;

    localparam logic [MW-1:0] c_move_reload = MW'(MOVE_PERIOD - 1);
    localparam logic [FW-1:0] c_fire_reload = FW'(FIRE_COOLDOWN - 1);
    localparam logic [6:0]    c_lo          = 7'd2;
    localparam logic [6:0]    c_x_hi        = 7'(GAME_W - 3);
    localparam logic [6:0]    c_y_hi        = 7'(GAME_H - 3);
    localparam logic [1:0]    c_up          = 2'd0;
    localparam logic [1:0]    c_dn          = 2'd1;
    localparam logic [1:0]    c_lt          = 2'd2;
    localparam logic [1:0]    c_rt          = 2'd3;

    state_t          r_state;
    logic [6:0]      r_x;
    logic [6:0]      r_y;
    logic [1:0]      r_dir;
    logic [MW-1:0]   r_move_cnt;
    logic [FW-1:0]   r_fire_cnt;
    logic [2:0]      r_k;
    logic            r_blocked;
    logic            r_chk_valid;
    logic [6:0]      r_chk_x;
    logic [6:0]      r_chk_y;
    logic            r_fire_pulse;
    logic [6:0]      r_fire_x;
    logic [6:0]      r_fire_y;
    logic [1:0]      r_fire_dir;
    logic            r_busy;

    logic            w_req;
    logic [1:0]      w_req_dir;
    logic            w_step_ok;
    logic [2:0]      w_k;
    logic [6:0]      w_cell_x;
    logic [6:0]      w_cell_y;
    logic [6:0]      w_muz_x;
    logic [6:0]      w_muz_y;

    always_comb begin
        w_req     = |i_btn;
        w_req_dir = c_up;
        if (i_btn[0])      w_req_dir = c_up;
        else if (i_btn[1]) w_req_dir = c_dn;
        else if (i_btn[2]) w_req_dir = c_lt;
        else if (i_btn[3]) w_req_dir = c_rt;
    end

    // Bounds are tested on the current centre so that every subtraction
    // below (leading edge and step) only runs when it cannot underflow.
    always_comb begin
        w_step_ok = 1'b0;
        case (r_dir)
            c_up:    w_step_ok = (r_y > c_lo);
            c_dn:    w_step_ok = (r_y < c_y_hi);
            c_lt:    w_step_ok = (r_x > c_lo);
            default: w_step_ok = (r_x < c_x_hi);
        endcase
    end

    assign w_k = (r_state == ST_IDLE) ? 3'd0 : (r_k + 3'd1);

    always_comb begin
        w_cell_x = r_x;
        w_cell_y = r_y;
        case (r_dir)
            c_up: begin
                w_cell_x = r_x - 7'd2 + {4'd0, w_k};
                w_cell_y = r_y - 7'd3;
            end
            c_dn: begin
                w_cell_x = r_x - 7'd2 + {4'd0, w_k};
                w_cell_y = r_y + 7'd3;
            end
            c_lt: begin
                w_cell_x = r_x - 7'd3;
                w_cell_y = r_y - 7'd2 + {4'd0, w_k};
            end
            default: begin
                w_cell_x = r_x + 7'd3;
                w_cell_y = r_y - 7'd2 + {4'd0, w_k};
            end
        endcase
    end

    always_comb begin
        w_muz_x = r_x;
        w_muz_y = r_y;
        case (r_dir)
            c_up:    w_muz_y = r_y - 7'd3;
            c_dn:    w_muz_y = r_y + 7'd3;
            c_lt:    w_muz_x = r_x - 7'd3;
            default: w_muz_x = r_x + 7'd3;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_x          <= 7'(INIT_X);
            r_y          <= 7'(INIT_Y);
            r_dir        <= 2'(INIT_DIR);
            r_move_cnt   <= '0;
            r_fire_cnt   <= '0;
            r_k          <= 3'd0;
            r_blocked    <= 1'b0;
            r_chk_valid  <= 1'b0;
            r_chk_x      <= 7'd0;
            r_chk_y      <= 7'd0;
            r_fire_pulse <= 1'b0;
            r_fire_x     <= 7'd0;
            r_fire_y     <= 7'd0;
            r_fire_dir   <= 2'd0;
            r_busy       <= 1'b0;
        end else begin
            r_fire_pulse <= 1'b0;

            if (i_tick && (r_move_cnt != '0)) begin
                r_move_cnt <= r_move_cnt - 1'b1;
            end

            // Fire samples r_dir/r_x/r_y before any same-cycle turn lands.
            if (i_tick) begin
                if (i_fire && (r_fire_cnt == '0)) begin
                    r_fire_pulse <= 1'b1;
                    r_fire_x     <= w_muz_x;
                    r_fire_y     <= w_muz_y;
                    r_fire_dir   <= r_dir;
                    r_fire_cnt   <= c_fire_reload;
                end else if (r_fire_cnt != '0) begin
                    r_fire_cnt <= r_fire_cnt - 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_tick && (r_move_cnt == '0) && w_req) begin
                        r_move_cnt <= c_move_reload;
                        if (w_req_dir != r_dir) begin
                            r_dir <= w_req_dir;
                        end else if (w_step_ok) begin
                            r_state     <= ST_CHECK;
                            r_blocked   <= 1'b0;
                            r_k         <= 3'd0;
                            r_chk_valid <= 1'b1;
                            r_chk_x     <= w_cell_x;
                            r_chk_y     <= w_cell_y;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    // Lookup k's result arrives one cycle later, so k=0 has none yet.
                    r_blocked <= r_blocked | ((r_k != 3'd0) & i_chk_wall);
                    if (r_k == 3'd4) begin
                        r_state     <= ST_WAIT;
                        r_chk_valid <= 1'b0;
                    end else begin
                        r_k     <= r_k + 3'd1;
                        r_chk_x <= w_cell_x;
                        r_chk_y <= w_cell_y;
                    end
                end
                ST_WAIT: begin
                    if (!(r_blocked | i_chk_wall)) begin
                        case (r_dir)
                            c_up:    r_y <= r_y - 7'd1;
                            c_dn:    r_y <= r_y + 7'd1;
                            c_lt:    r_x <= r_x - 7'd1;
                            default: r_x <= r_x + 7'd1;
                        endcase
                    end
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_chk_valid  = r_chk_valid;
    assign o_chk_x      = r_chk_x;
    assign o_chk_y      = r_chk_y;
    assign o_tank_x     = r_x;
    assign o_tank_y     = r_y;
    assign o_tank_dir   = r_dir;
    assign o_fire_pulse = r_fire_pulse;
    assign o_fire_x     = r_fire_x;
    assign o_fire_y     = r_fire_y;
    assign o_fire_dir   = r_fire_dir;
    assign o_busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tank_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tank_motion_ctrl
// Brief    : Directed self-checking bench for tank_motion_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tank_motion_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_tick;
    logic [3:0] i_btn;
    logic       i_fire;
    logic       o_chk_valid;
    logic [6:0] o_chk_x;
    logic [6:0] o_chk_y;
    logic       i_chk_wall;
    logic [6:0] o_tank_x;
    logic [6:0] o_tank_y;
    logic [1:0] o_tank_dir;
    logic       o_fire_pulse;
    logic [6:0] o_fire_x;
    logic [6:0] o_fire_y;
    logic [1:0] o_fire_dir;
    logic       o_busy;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    tank_motion_ctrl dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_tick       (i_tick),
        .i_btn        (i_btn),
        .i_fire       (i_fire),
        .o_chk_valid  (o_chk_valid),
        .o_chk_x      (o_chk_x),
        .o_chk_y      (o_chk_y),
        .i_chk_wall   (i_chk_wall),
        .o_tank_x     (o_tank_x),
        .o_tank_y     (o_tank_y),
        .o_tank_dir   (o_tank_dir),
        .o_fire_pulse (o_fire_pulse),
        .o_fire_x     (o_fire_x),
        .o_fire_y     (o_fire_y),
        .o_fire_dir   (o_fire_dir),
        .o_busy       (o_busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_x", 16'(o_tank_x), 16'd10);
        chk("rst_y", 16'(o_tank_y), 16'd24);
        chk("rst_dir", 16'(o_tank_dir), 16'd0);
        chk("rst_chk_valid", 16'(o_chk_valid), 16'd0);
        chk("rst_fire_pulse", 16'(o_fire_pulse), 16'd0);
        chk("rst_busy", 16'(o_busy), 16'd0);
        chk("rst_chk_x", 16'(o_chk_x), 16'd0);
        chk("rst_fire_x", 16'(o_fire_x), 16'd0);
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        #1;
        chk_reset_vals();
        step();
        i_rst_n = 1'b1;
    endtask

    // Three ticks that only count the move timer down; nothing may move.
    task automatic drain(input logic [3:0] btn, input logic [1:0] exp_dir);
        i_btn = btn;
        repeat (3) begin
            i_tick = 1'b1;
            step();
            i_tick = 1'b0;
            chk("drain_busy", 16'(o_busy), 16'd0);
            chk("drain_valid", 16'(o_chk_valid), 16'd0);
            chk("drain_dir", 16'(o_tank_dir), 16'(exp_dir));
            step();
        end
    endtask

    // One accepted step: tick, five lookups, wait, then final position.
    // vary_x selects whether the leading edge runs along x (up/down) or y.
    task automatic do_move(input logic [3:0] btn, input logic [4:0] wall,
                           input logic [6:0] ax, input logic [6:0] ay, input logic vary_x,
                           input logic [6:0] ex, input logic [6:0] ey);
        i_btn  = btn;
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("chk_valid", 16'(o_chk_valid), 16'd1);
            chk("chk_busy", 16'(o_busy), 16'd1);
            chk("chk_x", 16'(o_chk_x), vary_x ? 16'(ax + 7'(k)) : 16'(ax));
            chk("chk_y", 16'(o_chk_y), vary_x ? 16'(ay) : 16'(ay + 7'(k)));
            i_chk_wall = (k == 0) ? 1'b1 : wall[k-1];
            step();
        end
        chk("wait_valid", 16'(o_chk_valid), 16'd0);
        chk("wait_busy", 16'(o_busy), 16'd1);
        i_chk_wall = wall[4];
        step();
        i_chk_wall = 1'b0;
        chk("done_busy", 16'(o_busy), 16'd0);
        chk("done_x", 16'(o_tank_x), 16'(ex));
        chk("done_y", 16'(o_tank_y), 16'(ey));
    endtask

    initial begin
        logic [6:0] y;
        i_rst_n    = 1'b0;
        i_tick     = 1'b0;
        i_btn      = 4'b0000;
        i_fire     = 1'b0;
        i_chk_wall = 1'b0;

        step();
        step();
        chk_reset_vals();
        i_rst_n = 1'b1;
        step();

        // Turn right: direction changes, position does not.
        i_btn  = 4'b1000;
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        chk("turn_dir", 16'(o_tank_dir), 16'd3);
        chk("turn_x", 16'(o_tank_x), 16'd10);
        chk("turn_busy", 16'(o_busy), 16'd0);
        step();
        drain(4'b1000, 2'd3);
        do_move(4'b1000, 5'b00000, 7'd13, 7'd22, 1'b0, 7'd11, 7'd24);

        // Wall on the third lookup blocks the step.
        drain(4'b1000, 2'd3);
        do_move(4'b1000, 5'b00100, 7'd14, 7'd22, 1'b0, 7'd11, 7'd24);

        // Turn up, then walk to the top boundary y=2.
        drain(4'b0001, 2'd3);
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        chk("turn_up_dir", 16'(o_tank_dir), 16'd0);
        step();
        y = 7'd24;
        for (int i = 0; i < 22; i++) begin
            drain(4'b0001, 2'd0);
            do_move(4'b0001, 5'b00000, 7'd9, y - 7'd3, 1'b1, 7'd11, y - 7'd1);
            y = y - 7'd1;
        end

        // At y=2 an up command is refused without any lookup.
        drain(4'b0001, 2'd0);
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        chk("edge_valid", 16'(o_chk_valid), 16'd0);
        chk("edge_busy", 16'(o_busy), 16'd0);
        step();
        chk("edge_y", 16'(o_tank_y), 16'd2);
        chk("edge_valid2", 16'(o_chk_valid), 16'd0);

        // The refusal reloaded the counter: three ticks do nothing; down beats left/right.
        drain(4'b1110, 2'd0);
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        chk("prio_dir", 16'(o_tank_dir), 16'd1);
        step();

        // Start a down move and reset during the k=2 lookup.
        drain(4'b0010, 2'd1);
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        chk("dn_x0", 16'(o_chk_x), 16'd9);
        chk("dn_y0", 16'(o_chk_y), 16'd5);
        step();
        step();
        chk("dn_x2", 16'(o_chk_x), 16'd11);
        chk("dn_valid2", 16'(o_chk_valid), 16'd1);
        #2;
        apply_reset();
        step();
        do_move(4'b0001, 5'b00000, 7'd8, 7'd21, 1'b1, 7'd10, 7'd23);

        // Fire with a tick every cycle: pulses after ticks 0, 30 and 60.
        apply_reset();
        i_btn  = 4'b0000;
        i_fire = 1'b1;
        i_tick = 1'b1;
        for (int n = 0; n < 65; n++) begin
            step();
            chk("fire_pulse", 16'(o_fire_pulse), (n == 0 || n == 30 || n == 60) ? 16'd1 : 16'd0);
            if (n == 0) begin
                chk("fire_x", 16'(o_fire_x), 16'd10);
                chk("fire_y", 16'(o_fire_y), 16'd21);
                chk("fire_dir", 16'(o_fire_dir), 16'd0);
            end
        end
        i_tick = 1'b0;
        i_fire = 1'b0;

        // Turn and fire on the same tick: bullet keeps the old direction.
        apply_reset();
        i_btn  = 4'b1000;
        i_fire = 1'b1;
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        i_fire = 1'b0;
        chk("tf_pulse", 16'(o_fire_pulse), 16'd1);
        chk("tf_fire_dir", 16'(o_fire_dir), 16'd0);
        chk("tf_fire_x", 16'(o_fire_x), 16'd10);
        chk("tf_fire_y", 16'(o_fire_y), 16'd21);
        chk("tf_tank_dir", 16'(o_tank_dir), 16'd3);
        step();
        chk("tf_pulse_end", 16'(o_fire_pulse), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
